fpu_issue_ctrl: RTL

Issue/writeback scheduler in front of the FPU datapath (fadd/fsub, fmul, fdiv, sign-inject and compare units). It accepts one FP op per cycle over a valid/ready handshake and gives each op a fixed latency per unit class. It reserves the single shared writeback slot at issue time, so results never collide. It also produces the unit-select, tag and start strobes the FPU result mux and the register file writeback need.

---
 rtl/fpu_issue_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/fpu_issue_ctrl.sv
// Issue/writeback scheduler for the FPU: fixed per-class latency, one shared
// writeback slot reserved at issue, and a non-pipelined fdiv occupancy counter.
module fpu_issue_ctrl #(
  parameter int LAT_ADD  = 2,
  parameter int LAT_MUL  = 2,
  parameter int LAT_DIV  = 8,
  parameter int LAT_MISC = 1,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [TAG_W-1:0] req_rd,
  output logic             div_start,
  output logic             div_busy,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_rd,
  output logic [1:0]       wb_sel,
  output logic             wb_illegal
);

  localparam int CNT_W = $clog2(LAT_DIV + 1);

  typedef enum logic [3:0] {
    OP_FADD = 4'd0, OP_FSUB = 4'd1, OP_FMUL = 4'd2, OP_FDIV = 4'd3,
    OP_FSGNJ = 4'd4, OP_FSGNJN = 4'd5, OP_FEQ = 4'd6, OP_FLT = 4'd7, OP_FLE = 4'd8
  } op_e;

  typedef enum logic [1:0] {SEL_ADD = 2'd0, SEL_MUL = 2'd1, SEL_DIV = 2'd2, SEL_MISC = 2'd3} sel_e;

  typedef struct packed {
    logic [TAG_W-1:0] rd;
    sel_e             sel;
    logic             ill;
  } slot_t;

  logic [LAT_DIV-1:0] resv_q, resv_d;
  slot_t              slot_q [LAT_DIV];
  slot_t              slot_d [LAT_DIV];
  logic [CNT_W-1:0]   div_cnt_q, div_cnt_d;

  int    op_lat;
  sel_e  op_sel;
  logic  op_ill;
  logic  op_is_div;
  logic  slot_conflict;
  logic  div_busy_int;
  logic  accept;

  always_comb begin
    op_lat    = LAT_MISC;
    op_sel    = SEL_MISC;
    op_ill    = 1'b0;
    op_is_div = 1'b0;
    case (op_e'(req_op))
      OP_FADD, OP_FSUB: begin op_lat = LAT_ADD; op_sel = SEL_ADD; end
      OP_FMUL:          begin op_lat = LAT_MUL; op_sel = SEL_MUL; end
      OP_FDIV:          begin op_lat = LAT_DIV; op_sel = SEL_DIV; op_is_div = 1'b1; end
      OP_FSGNJ, OP_FSGNJN, OP_FEQ, OP_FLT, OP_FLE: op_lat = LAT_MISC;
      default:          op_ill = 1'b1;
    endcase
  end

  // Slot L-1 is loaded after the shift, so the slot that would shift into it
  // (resv_q[L]) must be free; slot LAT_DIV does not exist and is always free.
  always_comb begin
    slot_conflict = 1'b0;
    for (int i = 1; i < LAT_DIV; i++) begin
      if (i == op_lat) slot_conflict = resv_q[i];
    end
  end

  assign div_busy_int = (div_cnt_q != '0);
  assign req_ready    = rstn && !flush && !slot_conflict && !(op_is_div && div_busy_int);
  assign accept       = req_valid && req_ready;
  assign div_start    = accept && op_is_div;

  always_comb begin
    resv_d = resv_q >> 1;
    for (int i = 0; i < LAT_DIV; i++) begin
      slot_d[i] = (i < LAT_DIV - 1) ? slot_q[i+1] : '0;
    end
    if (accept) begin
      for (int i = 0; i < LAT_DIV; i++) begin
        if (i == op_lat - 1) begin
          resv_d[i] = 1'b1;
          slot_d[i] = '{rd: req_rd, sel: op_sel, ill: op_ill};
        end
      end
    end
    // Counting the accept cycle, the divider is free again in its writeback cycle.
    div_cnt_d = div_busy_int ? div_cnt_q - 1'b1 : '0;
    if (div_start) div_cnt_d = CNT_W'(LAT_DIV - 1);
  end

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      resv_q    <= '0;
      div_cnt_q <= '0;
      // NOTE: payload slots are cleared too so wb_rd/wb_sel read 0 whenever wb_valid is low.
      for (int i = 0; i < LAT_DIV; i++) slot_q[i] <= '0;
    end else begin
      resv_q    <= resv_d;
      div_cnt_q <= div_cnt_d;
      for (int i = 0; i < LAT_DIV; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign wb_valid   = rstn && resv_q[0];
  assign wb_rd      = rstn ? slot_q[0].rd : '0;
  assign wb_sel     = rstn ? slot_q[0].sel : SEL_ADD;
  assign wb_illegal = rstn && slot_q[0].ill;
  assign div_busy   = rstn && div_busy_int;

endmodule
